// File: rtl/vga_pkg.sv
// Shared VGA plot-port types and constants for the 160x120 adapter.
package vga_pkg;

  localparam int unsigned VGA_W  = 160;
  localparam int unsigned VGA_H  = 120;
  localparam int unsigned VGA_XW = 8;
  localparam int unsigned VGA_YW = 7;
  localparam int unsigned VGA_CW = 3;

  typedef struct packed {
    logic [VGA_XW-1:0] x;
    logic [VGA_YW-1:0] y;
    logic [VGA_CW-1:0] colour;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    RELEASE
  } arb_state_e;

  // True when the pixel lands inside the visible 160x120 frame.
  function automatic logic pixel_on_screen(input pixel_t p);
    return (p.x < VGA_XW'(VGA_W)) && (p.y < VGA_YW'(VGA_H));
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req scanning from rr_ptr upward
// (wrapping modulo NUM_CLIENTS).
module rr_pick #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned IW          = 2
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IW-1:0]          rr_ptr,
  output logic                   valid,
  output logic [IW-1:0]          idx
);

  int unsigned cand;

  // Scan rr_ptr, rr_ptr+1, ... and keep the first requester found.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      cand = (32'(rr_ptr) + k) % NUM_CLIENTS;
      if (!valid && req[IW'(cand)]) begin
        valid = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin, burst-locked arbiter sharing the vga_adapter plot port between
// NUM_CLIENTS drawing engines. Pixel outputs and grant are registered.
// Optional feature: define VGA_CLIP_EN to drop off-screen pixels (they still count
// toward the burst length).
module vga_plot_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned MAX_BURST   = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        req,
  input  logic [NUM_CLIENTS-1:0]        cl_plot,
  input  logic [8*NUM_CLIENTS-1:0]      cl_x,
  input  logic [7*NUM_CLIENTS-1:0]      cl_y,
  input  logic [3*NUM_CLIENTS-1:0]      cl_colour,
  output logic [NUM_CLIENTS-1:0]        gnt,
  output logic [7:0]                    vga_x,
  output logic [6:0]                    vga_y,
  output logic [2:0]                    vga_colour,
  output logic                          vga_plot,
  output logic                          busy
);

  localparam int unsigned IW = $clog2(NUM_CLIENTS);
  localparam int unsigned BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CLIENTS - 1);

  arb_state_e             state, state_nxt;
  logic [IW-1:0]          owner, owner_nxt;
  logic [IW-1:0]          rr_ptr, rr_ptr_nxt;
  logic [BW-1:0]          burst_cnt, burst_cnt_nxt, burst_seen;
  logic [NUM_CLIENTS-1:0] gnt_nxt;
  pixel_t                 pix_q, pix_nxt, own_pix;
  logic                   plot_q, plot_nxt;
  logic                   pick_valid;
  logic [IW-1:0]          pick_idx;
  logic                   accept, others_req, exit_own;

  function automatic logic [NUM_CLIENTS-1:0] onehot(input logic [IW-1:0] i);
    return {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << i;
  endfunction

  rr_pick #(
    .NUM_CLIENTS(NUM_CLIENTS),
    .IW         (IW)
  ) u_rr_pick (
    .req   (req),
    .rr_ptr(rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Select the current owner's pixel fields from the packed client buses.
  always_comb begin
    own_pix        = '0;
    own_pix.x      = cl_x[VGA_XW*owner +: VGA_XW];
    own_pix.y      = cl_y[VGA_YW*owner +: VGA_YW];
    own_pix.colour = cl_colour[VGA_CW*owner +: VGA_CW];
  end

  // Owner acceptance, saturating burst count and exit decision.
  // Preemption compares the count including this cycle's pixel, so an owner that
  // plots every cycle emits exactly MAX_BURST pixels per grant.
  always_comb begin
    accept     = (state == OWN) && cl_plot[owner];
    others_req = |(req & ~onehot(owner));
    burst_seen = burst_cnt;
    if (accept && (burst_cnt != BURST_MAX))
      burst_seen = burst_cnt + BW'(1);
    exit_own = !req[owner] ||
               ((MAX_BURST != 0) && (burst_seen == BURST_MAX) && others_req);
  end

  // Next-state and next-register values for the IDLE/OWN/RELEASE arbiter.
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    gnt_nxt       = gnt;
    pix_nxt       = pix_q;
    plot_nxt      = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt     = OWN;
          owner_nxt     = pick_idx;
          gnt_nxt       = onehot(pick_idx);
          burst_cnt_nxt = '0;
        end
      end
      OWN: begin
        burst_cnt_nxt = burst_seen;
`ifdef VGA_CLIP_EN
        if (accept && pixel_on_screen(own_pix)) begin
`else
        if (accept) begin
`endif
          pix_nxt  = own_pix;
          plot_nxt = 1'b1;
        end
        if (exit_own) begin
          state_nxt  = RELEASE;
          gnt_nxt    = '0;
          rr_ptr_nxt = (owner == LAST_IDX) ? '0 : owner + IW'(1);
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grant, arbitration bookkeeping and registered pixel outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      gnt       <= '0;
      pix_q     <= '0;
      plot_q    <= 1'b0;
    end else begin
      owner     <= owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
      gnt       <= gnt_nxt;
      pix_q     <= pix_nxt;
      plot_q    <= plot_nxt;
    end
  end

  assign vga_x      = pix_q.x;
  assign vga_y      = pix_q.y;
  assign vga_colour = pix_q.colour;
  assign vga_plot   = plot_q;
  assign busy       = (state == OWN);

endmodule
